// File: rtl/timer_prog.sv
// Programmable interval timer: runtime terminal value, clock prescaler, one-shot or
// periodic mode, registered done pulse, sticky irq and count readback.
module timer_prog #(
    parameter int WIDTH          = 16,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      mode,
    input  logic [WIDTH-1:0]          load_value,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      irq_clear,
    output logic [WIDTH-1:0]          count,
    output logic                      done,
    output logic                      irq,
    output logic                      busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [PRESCALE_WIDTH-1:0] prescaler;
    logic [WIDTH-1:0]          shadow_load;
    logic [PRESCALE_WIDTH-1:0] shadow_prescale;
    logic                      shadow_mode;
    logic                      tick;
    logic                      terminal;

    // A pending stop or start overrides any tick in the same cycle, so neither can
    // produce a done pulse.
    assign tick     = (state == RUN) && enable && !stop && !start &&
                      (prescaler == shadow_prescale);
    assign terminal = tick && (count == shadow_load);
    assign busy     = (state == RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        if (stop) begin
            state_next = IDLE;
        end else if (start) begin
            state_next = RUN;
        end else if (terminal && !shadow_mode) begin
            state_next = IDLE;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so the ordering of
    // reads and writes within an edge never matters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count           <= '0;
            prescaler       <= '0;
            shadow_load     <= '0;
            shadow_prescale <= '0;
            shadow_mode     <= 1'b0;
            done            <= 1'b0;
            irq             <= 1'b0;
        end else begin
            done <= terminal;
            irq  <= terminal | (irq & ~irq_clear);
            if (stop) begin
                // Counters hold so software can read back where the run stopped.
            end else if (start) begin
                shadow_load     <= load_value;
                shadow_prescale <= prescale;
                shadow_mode     <= mode;
                count           <= '0;
                prescaler       <= '0;
            end else if (tick) begin
                prescaler <= '0;
                if (count != shadow_load) begin
                    count <= count + 1'b1;
                end else if (shadow_mode) begin
                    count <= '0;
                end
            end else if ((state == RUN) && enable) begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_timer_prog.sv
// Scoreboard bench for timer_prog: stimulus pushes expected done-pulse cycles, monitors
// pop and compare whenever done is seen; count/busy/irq are checked directly.
module tb_timer_prog;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable, start, stop, mode, irq_clear;
    logic [15:0] load_value;
    logic [7:0]  prescale;
    logic [15:0] count;
    logic        done, irq, busy;

    logic        w4_start, w4_stop, w4_mode;
    logic [3:0]  w4_load;
    logic [7:0]  w4_presc;
    logic [3:0]  w4_count;
    logic        w4_done, w4_irq, w4_busy;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int exp_q[$];
    int exp4_q[$];

    timer_prog #(.WIDTH(16), .PRESCALE_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .start(start), .stop(stop),
        .mode(mode), .load_value(load_value), .prescale(prescale), .irq_clear(irq_clear),
        .count(count), .done(done), .irq(irq), .busy(busy)
    );

    timer_prog #(.WIDTH(4), .PRESCALE_WIDTH(8)) dut_w4 (
        .clk(clk), .reset_n(reset_n), .enable(1'b1), .start(w4_start), .stop(w4_stop),
        .mode(w4_mode), .load_value(w4_load), .prescale(w4_presc), .irq_clear(1'b0),
        .count(w4_count), .done(w4_done), .irq(w4_irq), .busy(w4_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Done-pulse monitors: every observed pulse must match the oldest expected cycle.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) check("unexpected_done", cyc, -1);
            else check("done_cycle", cyc, exp_q.pop_front());
        end
        if (w4_done) begin
            if (exp4_q.size() == 0) check("w4_unexpected_done", cyc, -1);
            else check("w4_done_cycle", cyc, exp4_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input logic m, input int ld, input int ps, output int s);
        mode       = m;
        load_value = ld[15:0];
        prescale   = ps[7:0];
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s     = cyc;
    endtask

    task automatic clear_irq();
        irq_clear = 1'b1;
        step(1);
        irq_clear = 1'b0;
        check("irq_cleared", irq, 0);
    endtask

    initial begin
        int s, s2, jeff;
        reset_n = 1'b0; enable = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
        irq_clear = 1'b0; load_value = '0; prescale = '0;
        w4_start = 1'b0; w4_stop = 1'b0; w4_mode = 1'b0; w4_load = '0; w4_presc = '0;
        step(2);
        check("rst_count", count, 0);
        check("rst_done", done, 0);
        check("rst_irq", irq, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        step(2);
        check("idle_after_rst", busy, 0);

        // Periodic, load 3, prescale 0.
        do_start(1'b1, 3, 0, s);
        exp_q.push_back(s + 4); exp_q.push_back(s + 8); exp_q.push_back(s + 12);
        for (int j = 0; j < 12; j++) begin
            check("p3_count", count, j % 4);
            check("p3_busy", busy, 1);
            step(1);
        end
        check("p3_irq", irq, 1);
        stop = 1'b1; step(1); stop = 1'b0;
        clear_irq();

        // One-shot, load 2, prescale 2.
        do_start(1'b0, 2, 2, s);
        exp_q.push_back(s + 9);
        for (int j = 0; j < 14; j++) begin
            check("os_count", count, (j < 9) ? j / 3 : 2);
            check("os_busy", busy, (j < 9) ? 1 : 0);
            step(1);
        end
        check("os_irq", irq, 1);
        clear_irq();

        // Periodic, load 5, prescale 1, enable low for 7 cycles mid-run.
        do_start(1'b1, 5, 1, s);
        exp_q.push_back(s + 19);
        for (int j = 0; j < 27; j++) begin
            jeff = j - ((j <= 5) ? 0 : ((j - 5 > 7) ? 7 : j - 5));
            check("gap_count", count, (jeff / 2) % 6);
            enable = !(j >= 5 && j < 12);
            step(1);
        end
        stop = 1'b1; step(1); stop = 1'b0;
        step(2);
        check("stop_hold_count", count, 4);
        check("stop_busy", busy, 0);
        clear_irq();

        // Load changed mid-run is ignored; restart at count 4 picks up load 9.
        do_start(1'b1, 7, 0, s);
        exp_q.push_back(s + 8);
        for (int j = 0; j <= 12; j++) begin
            check("shadow_count", count, j % 8);
            if (j == 2) load_value = 16'd9;
            if (j < 12) step(1);
        end
        do_start(1'b1, 9, 0, s2);
        exp_q.push_back(s2 + 10);
        for (int j = 0; j <= 12; j++) begin
            check("restart_count", count, j % 10);
            if (j < 12) step(1);
        end
        stop = 1'b1; start = 1'b1; step(1); stop = 1'b0; start = 1'b0;
        check("stop_start_count", count, 2);
        check("stop_start_busy", busy, 0);
        step(1);
        check("stop_start_held", count, 2);
        clear_irq();

        // irq_clear coinciding with a terminal tick loses to the set.
        do_start(1'b1, 1, 0, s);
        exp_q.push_back(s + 2); exp_q.push_back(s + 4);
        step(1);
        check("irq_pre", irq, 0);
        irq_clear = 1'b1; step(1); irq_clear = 1'b0;
        check("irq_set_wins", irq, 1);
        irq_clear = 1'b1; step(1); irq_clear = 1'b0;
        check("irq_clear_alone", irq, 0);
        step(1);
        check("irq_reset_again", irq, 1);
        stop = 1'b1; step(1); stop = 1'b0;

        // Asynchronous reset mid-run at count 3.
        do_start(1'b1, 5, 0, s);
        step(3);
        check("pre_rst_count", count, 3);
        #2 reset_n = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_busy", busy, 0);
        check("arst_irq", irq, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(4);
        check("post_rst_count", count, 0);
        check("post_rst_busy", busy, 0);

        // load 0, prescale 0: done every cycle, count stays 0.
        do_start(1'b1, 0, 0, s);
        for (int k = 1; k <= 6; k++) exp_q.push_back(s + k);
        for (int j = 0; j < 7; j++) begin
            check("l0_count", count, 0);
            if (j == 6) stop = 1'b1;
            step(1);
        end
        stop = 1'b0;
        check("l0_no_done_after_stop", done, 0);
        clear_irq();

        // 4-bit instance: all-ones load wraps cleanly to 0.
        w4_mode = 1'b1; w4_load = 4'd15; w4_presc = 8'd0; w4_start = 1'b1;
        step(1);
        w4_start = 1'b0;
        s = cyc;
        exp4_q.push_back(s + 16);
        for (int j = 0; j < 21; j++) begin
            check("w4_count", w4_count, j % 16);
            step(1);
        end
        w4_stop = 1'b1; step(1); w4_stop = 1'b0;
        check("w4_irq", w4_irq, 1);
        check("w4_busy", w4_busy, 0);

        step(3);
        check("dones_outstanding", exp_q.size(), 0);
        check("w4_dones_outstanding", exp4_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
